ddr3_cmd_arbiter: RTL

//  Shares the single DDR3 MIG command port (app_en/app_cmd/app_addr/app_rdy) between the write-address requester (ddr3_wr_control)
//  and the read-address requester (readout path). Grants one direction at a time, with a burst limit and a turnaround gap on

---
 rtl/ddr3_cmd_arbiter_if.sv | 24 ++
 rtl/ddr3_cmd_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ddr3_cmd_arbiter_if.sv
// Shared DDR3 MIG command port: write/read address requesters
// on one side, MIG user-interface command channel on the other.
interface ddr3_cmd_arbiter_if;
  logic        wr_app_en;
  logic [25:0] wr_addr;
  logic        wr_app_rdy;
  logic        rd_app_en;
  logic [25:0] rd_addr;
  logic        rd_app_rdy;
  logic        app_en;
  logic [2:0]  app_cmd;
  logic [25:0] app_addr;
  logic        app_rdy;

  modport master (
    output wr_app_en, wr_addr, rd_app_en, rd_addr, app_rdy,
    input  wr_app_rdy, rd_app_rdy, app_en, app_cmd, app_addr
  );

  modport slave (
    input  wr_app_en, wr_addr, rd_app_en, rd_addr, app_rdy,
    output wr_app_rdy, rd_app_rdy, app_en, app_cmd, app_addr
  );
endinterface

// File: rtl/ddr3_cmd_arbiter.sv
// Write/read command arbiter for the MIG port with burst limit and turnaround.
// Optional accept counters under DDR3_ARB_STATS_EN.
module ddr3_cmd_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int TURN_CYC  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  ddr3_cmd_arbiter_if.slave bus,
  output logic              arb_dir
`ifdef DDR3_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [31:0]       wr_cmd_cnt,
  output logic [31:0]       rd_cmd_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    GNT_WR,
    GNT_RD,
    TURN
  } state_e;

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);
  localparam logic [3:0] TURN_LAST = 4'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
  localparam bit         TURN_EN   = (TURN_CYC > 0);

  state_e      state_q, state_d;
  logic        last_dir_q, last_dir_d;
  logic        pend_dir_q, pend_dir_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic [3:0]  turn_cnt_q, turn_cnt_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [25:0] addr_q, addr_d;

  logic        app_en, wr_rdy, rd_rdy, accept;
  logic [2:0]  app_cmd;
  logic [25:0] app_addr;
  logic        go, go_dir, own_en, oth_en, pend_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_dir_q  <= 1'b1;
      pend_dir_q  <= 1'b0;
      burst_cnt_q <= '0;
      turn_cnt_q  <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_dir_q  <= last_dir_d;
      pend_dir_q  <= pend_dir_d;
      burst_cnt_q <= burst_cnt_d;
      turn_cnt_q  <= turn_cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_dir_d  = last_dir_q;
    pend_dir_d  = pend_dir_q;
    burst_cnt_d = burst_cnt_q;
    turn_cnt_d  = turn_cnt_q;
    go          = 1'b0;
    go_dir      = 1'b0;
    own_en      = (state_q == GNT_RD) ? bus.rd_app_en : bus.wr_app_en;
    oth_en      = (state_q == GNT_RD) ? bus.wr_app_en : bus.rd_app_en;
    pend_en     = pend_dir_q ? bus.rd_app_en : bus.wr_app_en;
    if (accept && burst_cnt_q != BURST_MAX)
      burst_cnt_d = burst_cnt_q + 8'd1;
    if (state_q == TURN && turn_cnt_q != 4'hf)
      turn_cnt_d = turn_cnt_q + 4'd1;
    unique case (state_q)
      IDLE: begin
        if (bus.wr_app_en || bus.rd_app_en) begin
          go     = 1'b1;
          go_dir = (bus.wr_app_en && bus.rd_app_en) ? !last_dir_q
                                                    : bus.rd_app_en;
        end
      end
      GNT_WR, GNT_RD: begin
        // a presented but unaccepted command pins the grant
        if (!own_en ||
            (oth_en && burst_cnt_d == BURST_MAX &&
             !(app_en && !bus.app_rdy))) begin
          if (oth_en) begin
            go     = 1'b1;
            go_dir = (state_q == GNT_WR);
          end else begin
            state_d = IDLE;
          end
        end
      end
      TURN: begin
        if (!pend_en) begin
          state_d = IDLE;
        end else if (turn_cnt_q == TURN_LAST) begin
          state_d     = pend_dir_q ? GNT_RD : GNT_WR;
          last_dir_d  = pend_dir_q;
          burst_cnt_d = '0;
        end
      end
    endcase
    if (go) begin
      if (go_dir != last_dir_q && TURN_EN) begin
        state_d    = TURN;
        pend_dir_d = go_dir;
        turn_cnt_d = '0;
      end else begin
        state_d     = go_dir ? GNT_RD : GNT_WR;
        last_dir_d  = go_dir;
        burst_cnt_d = '0;
      end
    end
  end

  always_comb begin
    app_en   = 1'b0;
    app_cmd  = cmd_q;
    app_addr = addr_q;
    wr_rdy   = 1'b0;
    rd_rdy   = 1'b0;
    unique case (state_q)
      GNT_WR: begin
        app_en   = bus.wr_app_en;
        app_cmd  = 3'b000;
        app_addr = bus.wr_addr;
        wr_rdy   = bus.app_rdy;
      end
      GNT_RD: begin
        app_en   = bus.rd_app_en;
        app_cmd  = 3'b001;
        app_addr = bus.rd_addr;
        rd_rdy   = bus.app_rdy;
      end
      default: ;
    endcase
    cmd_d  = app_cmd;
    addr_d = app_addr;
    accept = app_en && bus.app_rdy;
  end

  assign bus.app_en     = app_en;
  assign bus.app_cmd    = app_cmd;
  assign bus.app_addr   = app_addr;
  assign bus.wr_app_rdy = wr_rdy;
  assign bus.rd_app_rdy = rd_rdy;
  assign arb_dir        = last_dir_q;

`ifdef DDR3_ARB_STATS_EN
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (stats_clr) begin
      wr_cnt_d = '0;
      rd_cnt_d = '0;
    end else begin
      if (accept && state_q == GNT_WR) wr_cnt_d = wr_cnt_q + 32'd1;
      if (accept && state_q == GNT_RD) rd_cnt_d = rd_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wr_cmd_cnt = wr_cnt_q;
  assign rd_cmd_cnt = rd_cnt_q;
`endif

endmodule
